// File: rtl/gray_cnt_ctrl.sv
// Sequencing controller for a free-running Gray counter: burst, pause and single-step
// control, a checker on the returned Gray code, and a saturating wrap counter.
module gray_cnt_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_step,
  input  logic [LEN_W-1:0] i_len,
  input  logic [WIDTH-1:0] i_gray,
  output logic             o_cnt_en,
  output logic             o_cnt_clr,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [LEN_W-1:0] o_wraps
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] MAX_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] ONE_L    = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] WRAP_MAX = {LEN_W{1'b1}};

  state_t           state;
  state_t           state_d;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] remaining_d;
  logic             free;
  logic             free_d;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] exp_gray;
  logic             prev_en;
  logic             prev_clr;
  logic             exp_valid;
  logic             exp_valid_d;
  logic             cnt_en_d;
  logic             cnt_clr_d;
  logic             busy_d;
  logic             done_d;
  logic             err_d;
  logic [LEN_W-1:0] wraps_d;
  logic             start_new;
  logic             rem_last;
  logic             step_en;
  logic             mismatch;
  logic             wrap_seen;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // The counter registers en/clr, so i_gray this cycle reflects last cycle's command.
  always_comb begin
    exp_gray = prev_gray;
    if (prev_clr) begin
      exp_gray = '0;
    end else if (prev_en) begin
      exp_gray = bin2gray(gray2bin(prev_gray) + ONE_W);
    end
    mismatch  = exp_valid && (i_gray != exp_gray);
    wrap_seen = exp_valid && prev_en && (prev_gray == MAX_CODE) && (i_gray == '0);
  end

  always_comb begin
    state_d   = state;
    start_new = 1'b0;
    step_en   = 1'b0;
    rem_last  = o_cnt_en && !free && (remaining == ONE_L);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (!i_stop && i_start) begin
          state_d   = ST_CLEAR;
          start_new = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: state_d = i_stop ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        // The enable issued this cycle still counts, so completion outranks a stop.
        if (rem_last) begin
          state_d = ST_DONE;
        end else if (i_stop) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (rem_last) begin
          state_d = ST_DONE;
        end else if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_start) begin
          state_d = ST_RUN;
        end else if (i_step) begin
          step_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_en_d    = (state_d == ST_RUN) || step_en;
    cnt_clr_d   = (state_d == ST_CLEAR);
    busy_d      = (state_d == ST_CLEAR) || (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d      = (state_d == ST_DONE);
    exp_valid_d = ((state_d == ST_RUN) || (state_d == ST_PAUSE) || (state_d == ST_DONE))
                  && ((state == ST_CLEAR) || exp_valid);
  end

  always_comb begin
    remaining_d = remaining;
    free_d      = free;
    err_d       = o_err;
    wraps_d     = o_wraps;
    if (start_new) begin
      remaining_d = i_len;
      free_d      = (i_len == '0);
      err_d       = 1'b0;
      wraps_d     = '0;
    end else begin
      if (o_cnt_en && !free && (remaining != '0)) begin
        remaining_d = remaining - ONE_L;
      end
      if (mismatch) begin
        err_d = 1'b1;
      end
      if (wrap_seen && (o_wraps != WRAP_MAX)) begin
        wraps_d = o_wraps + ONE_L;
      end
    end
  end

  always_ff @(posedge i_clk or posedge rst_n) begin
    if (rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge rst_n) begin
    if (rst_n) begin
      remaining <= '0;
      free      <= 1'b0;
      prev_gray <= '0;
      prev_en   <= 1'b0;
      prev_clr  <= 1'b0;
      exp_valid <= 1'b0;
      o_cnt_en  <= 1'b0;
      o_cnt_clr <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_wraps   <= '0;
    end else begin
      remaining <= remaining_d;
      free      <= free_d;
      prev_gray <= i_gray;
      prev_en   <= o_cnt_en;
      prev_clr  <= o_cnt_clr;
      exp_valid <= exp_valid_d;
      o_cnt_en  <= cnt_en_d;
      o_cnt_clr <= cnt_clr_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
      o_err     <= err_d;
      o_wraps   <= wraps_d;
    end
  end

endmodule

// File: tb/tb_gray_cnt_ctrl.sv
// Bench for gray_cnt_ctrl: models the Gray counter it drives and checks bursts,
// pause/step, error detection, mid-burst reset and control priorities.
`timescale 1ns/1ps
module tb_gray_cnt_ctrl;
  localparam int WIDTH = 4;
  localparam int LEN_W = 8;
  localparam int SW    = WIDTH + 2 * LEN_W;  // {gray, wraps, en_cycles}

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             step;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] cnt_bin;
  logic [WIDTH-1:0] cnt_gray;
  logic             inject;
  logic [WIDTH-1:0] inject_val;
  logic             cnt_en;
  logic             cnt_clr;
  logic             busy;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] wraps;

  int n_cmp = 0;
  int n_fail = 0;
  int en_count = 0;
  int done_count = 0;
  int clr_count = 0;
  logic [SW-1:0] exp_q[$];

  always #5 clk = ~clk;

  gray_cnt_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .i_clk    (clk),
    .rst_n    (rst_n),
    .i_start  (start),
    .i_stop   (stop),
    .i_step   (step),
    .i_len    (len),
    .i_gray   (gray_in),
    .o_cnt_en (cnt_en),
    .o_cnt_clr(cnt_clr),
    .o_busy   (busy),
    .o_done   (done),
    .o_err    (err),
    .o_wraps  (wraps)
  );

  // Counter datapath model: binary count, Gray presented on the output.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)        cnt_bin <= '0;
    else if (cnt_clr) cnt_bin <= '0;
    else if (cnt_en)  cnt_bin <= cnt_bin + 1'b1;
  end
  assign cnt_gray = cnt_bin ^ (cnt_bin >> 1);
  assign gray_in  = inject ? inject_val : cnt_gray;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (cnt_en)  en_count++;
      if (done)    done_count++;
      if (cnt_clr) clr_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1);
  end

  function automatic logic [WIDTH-1:0] b2g(input int b);
    logic [WIDTH-1:0] x;
    x = WIDTH'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] l);
    len   = l;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic wait_en(input int n, output bit ok);
    int k = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (cnt_en) k++;
      if (k == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 0; stop = 0; step = 0; len = '0; inject = 0; inject_val = '0;
    #1000;
    n_cmp++;
    if ({cnt_en, cnt_clr, busy, done, err, wraps} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero", {cnt_en, cnt_clr, busy, done, err, wraps});
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    tick; tick;
    n_cmp++;
    if ({cnt_en, cnt_clr, busy, done, err, wraps} !== '0 || en_count != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: outputs %b en_count %0d expected zero", {cnt_en, cnt_clr, busy, done, err, wraps}, en_count);
    end
  endtask

  task automatic test_burst(input int l);
    logic [SW-1:0] rec;
    bit seen;
    int e0, d0, c0;
    e0 = en_count; d0 = done_count; c0 = clr_count;
    exp_q.push_back({b2g(l), LEN_W'(l / 16), LEN_W'(l)});
    pulse_start(LEN_W'(l));
    n_cmp++;
    if (cnt_clr !== 1'b1 || busy !== 1'b1 || cnt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL burst%0d_clear: clr=%b busy=%b en=%b expected 1/1/0", l, cnt_clr, busy, cnt_en);
    end
    wait_done(l + 20, seen);
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL burst%0d_timeout: done not seen, expected within %0d cycles", l, l + 20);
    end
    rec = exp_q.pop_front();
    n_cmp++;
    if (cnt_gray !== rec[SW-1 -: WIDTH]) begin
      n_fail++;
      $display("FAIL burst%0d_gray: got %b expected %b", l, cnt_gray, rec[SW-1 -: WIDTH]);
    end
    n_cmp++;
    if (wraps !== rec[LEN_W +: LEN_W]) begin
      n_fail++;
      $display("FAIL burst%0d_wraps: got %0d expected %0d", l, wraps, rec[LEN_W +: LEN_W]);
    end
    n_cmp++;
    if (en_count - e0 != int'(rec[LEN_W-1:0]) || err !== 1'b0) begin
      n_fail++;
      $display("FAIL burst%0d_en: en cycles %0d err %b expected %0d / 0", l, en_count - e0, err, rec[LEN_W-1:0]);
    end
    tick;
    n_cmp++;
    if (done !== 1'b0 || done_count - d0 != 1 || clr_count - c0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL burst%0d_pulses: done=%b dones=%0d clrs=%0d busy=%b expected 0/1/1/0", l, done, done_count - d0, clr_count - c0, busy);
    end
  endtask

  task automatic test_pause_step;
    bit ok;
    int e0, d0;
    logic [WIDTH-1:0] exp_g;
    e0 = en_count; d0 = done_count;
    pulse_start('0);
    wait_en(7, ok);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    n_cmp++;
    if (!ok || cnt_en !== 1'b0 || busy !== 1'b1 || cnt_gray !== 4'b0100) begin
      n_fail++;
      $display("FAIL pause_entry: ok=%b en=%b busy=%b gray=%b expected 1/0/1/0100", ok, cnt_en, busy, cnt_gray);
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(SW'(b2g(8 + k)));
      step = 1'b1;
      tick;
      step = 1'b0;
      n_cmp++;
      if (cnt_en !== 1'b1) begin
        n_fail++;
        $display("FAIL step%0d_en: got %b expected 1", k, cnt_en);
      end
      tick;
      exp_g = exp_q.pop_front()[WIDTH-1:0];
      n_cmp++;
      if (cnt_gray !== exp_g || cnt_en !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL step%0d_gray: gray=%b en=%b busy=%b expected %b/0/1", k, cnt_gray, cnt_en, busy, exp_g);
      end
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    tick; tick;
    n_cmp++;
    if (busy !== 1'b0 || done_count != d0 || en_count - e0 != 10 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_abort: busy=%b dones=%0d en=%0d err=%b expected 0/0/10/0", busy, done_count - d0, en_count - e0, err);
    end
  endtask

  task automatic test_error;
    bit seen;
    for (int v = 0; v < 2; v++) begin
      pulse_start(8'd3);
      tick; tick;
      inject     = 1'b1;
      inject_val = (v == 0) ? 4'b0011 : 4'b0000;
      tick;
      inject = 1'b0;
      n_cmp++;
      if (err !== 1'b1) begin
        n_fail++;
        $display("FAIL err%0d_set: got %b expected 1", v, err);
      end
      wait_done(20, seen);
      n_cmp++;
      if (!seen || err !== 1'b1) begin
        n_fail++;
        $display("FAIL err%0d_done: seen=%b err=%b expected 1/1", v, seen, err);
      end
      tick;
      n_cmp++;
      if (err !== 1'b1) begin
        n_fail++;
        $display("FAIL err%0d_sticky: got %b expected 1", v, err);
      end
    end
    pulse_start(8'd2);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_on_start: got %b expected 0", err);
    end
    wait_done(20, seen);
    n_cmp++;
    if (!seen || err !== 1'b0 || cnt_gray !== 4'b0011) begin
      n_fail++;
      $display("FAIL err_clean_burst: seen=%b err=%b gray=%b expected 1/0/0011", seen, err, cnt_gray);
    end
    tick;
  endtask

  task automatic test_mid_reset;
    bit ok;
    int d0;
    d0 = done_count;
    pulse_start(8'd10);
    wait_en(4, ok);
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (!ok || {cnt_en, cnt_clr, busy, done, err, wraps} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ok=%b outputs %b expected 1 / all zero", ok, {cnt_en, cnt_clr, busy, done, err, wraps});
    end
    tick; tick;
    rst_n = 1'b0;
    tick; tick;
    n_cmp++;
    if (busy !== 1'b0 || done_count != d0) begin
      n_fail++;
      $display("FAIL reset_no_done: busy=%b dones=%0d expected 0/0", busy, done_count - d0);
    end
    test_burst(10);
  endtask

  task automatic test_priority;
    bit ok;
    int e0;
    pulse_start('0);
    wait_en(3, ok);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    e0 = en_count;
    stop = 1'b1; step = 1'b1;
    tick;
    stop = 1'b0; step = 1'b0;
    tick;
    n_cmp++;
    if (!ok || busy !== 1'b0 || cnt_en !== 1'b0 || en_count != e0) begin
      n_fail++;
      $display("FAIL stop_over_step: ok=%b busy=%b en=%b extra_en=%0d expected 1/0/0/0", ok, busy, cnt_en, en_count - e0);
    end
    e0 = en_count;
    pulse_start('0);
    wait_en(2, ok);
    start = 1'b1;
    tick;
    n_cmp++;
    if (!ok || cnt_en !== 1'b1 || busy !== 1'b1 || cnt_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_run: ok=%b en=%b busy=%b clr=%b expected 1/1/1/0", ok, cnt_en, busy, cnt_clr);
    end
    stop = 1'b1;
    tick;
    stop = 1'b0; start = 1'b0;
    n_cmp++;
    if (cnt_en !== 1'b0 || busy !== 1'b1 || en_count - e0 != 3) begin
      n_fail++;
      $display("FAIL stop_over_start: en=%b busy=%b en_cycles=%0d expected 0/1/3", cnt_en, busy, en_count - e0);
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    tick;
  endtask

  task automatic test_start_ignored;
    logic [SW-1:0] rec;
    bit seen;
    int e0;
    e0 = en_count;
    exp_q.push_back({b2g(6), LEN_W'(0), LEN_W'(6)});
    pulse_start(8'd6);
    tick; tick;
    start = 1'b1;
    tick; tick;
    start = 1'b0;
    wait_done(30, seen);
    rec = exp_q.pop_front();
    n_cmp++;
    if (!seen || cnt_gray !== rec[SW-1 -: WIDTH] || en_count - e0 != int'(rec[LEN_W-1:0])) begin
      n_fail++;
      $display("FAIL start_ignored: seen=%b gray=%b en=%0d expected 1/%b/%0d", seen, cnt_gray, en_count - e0, rec[SW-1 -: WIDTH], rec[LEN_W-1:0]);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    bit seen;
    int e0;
    e0 = en_count;
    pulse_start(8'd3);
    wait_done(20, seen);
    len   = 8'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++;
    if (!seen || cnt_clr !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart: seen=%b clr=%b busy=%b done=%b expected 1/1/1/0", seen, cnt_clr, busy, done);
    end
    wait_done(20, seen);
    n_cmp++;
    if (!seen || en_count - e0 != 7 || cnt_gray !== 4'b0110) begin
      n_fail++;
      $display("FAIL b2b_second: seen=%b en=%0d gray=%b expected 1/7/0110", seen, en_count - e0, cnt_gray);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_burst(5);
    test_burst(20);
    test_pause_step;
    test_error;
    test_mid_reset;
    test_priority;
    test_start_ignored;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
